// File: rtl/wb_regfile.sv
// ============================================================================
//  Module   : wb_regfile
//  Summary  : Writeback stage (load formatting, result select) and
//             architectural register file with write-first bypass.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_regfile #(
  parameter int D_WIDTH = 32,
  parameter int RF_SIZE = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [D_WIDTH-1:0] alu_out_wb,
  input  logic [D_WIDTH-1:0] mem_data_wb,
  input  logic [RF_SIZE-1:0] rd_wb,
  input  logic               reg_write_wb,
  input  logic               mem_to_reg_wb,
  input  logic [1:0]         load_size_wb,
  input  logic               load_unsigned_wb,
  input  logic [RF_SIZE-1:0] rs1_addr,
  input  logic [RF_SIZE-1:0] rs2_addr,
  output logic [D_WIDTH-1:0] rs1_data,
  output logic [D_WIDTH-1:0] rs2_data,
  output logic [D_WIDTH-1:0] wb_data,
  output logic [31:0]        wr_count
);

  localparam int          NREGS   = 1 << RF_SIZE;
  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;

  logic [1:0]         w_off;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [D_WIDTH-1:0] w_load;
  logic               w_commit;

  logic [D_WIDTH-1:0] regs_q [1:NREGS-1];
  logic [D_WIDTH-1:0] regs_d [1:NREGS-1];
  logic [31:0]        wr_count_q;
  logic [31:0]        wr_count_d;

  assign w_off  = alu_out_wb[1:0];
  assign w_byte = mem_data_wb[8*w_off +: 8];
  assign w_half = mem_data_wb[16*w_off[1] +: 16];

  always_comb begin
    w_load = mem_data_wb;
    case (load_size_wb)
      SZ_BYTE: w_load = {{(D_WIDTH-8){w_byte[7] & ~load_unsigned_wb}}, w_byte};
      SZ_HALF: w_load = {{(D_WIDTH-16){w_half[15] & ~load_unsigned_wb}}, w_half};
      default: w_load = mem_data_wb;
    endcase
  end

  assign wb_data  = mem_to_reg_wb ? w_load : alu_out_wb;
  // Writes to x0 are dropped entirely, including from the counter and bypass.
  assign w_commit = reg_write_wb && (rd_wb != '0);

  generate
    for (genvar i = 1; i < NREGS; i++) begin : g_reg
      always_comb begin
        regs_d[i] = regs_q[i];
        if (w_commit && (rd_wb == RF_SIZE'(i))) regs_d[i] = wb_data;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q[i] <= '0;
        else        regs_q[i] <= regs_d[i];
      end
    end
  endgenerate

  always_comb begin
    wr_count_d = wr_count_q;
    if (w_commit) wr_count_d = wr_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_count_q <= '0;
    else        wr_count_q <= wr_count_d;
  end

  assign wr_count = wr_count_q;

  // Write-first: a commit in flight is visible to decode in the same cycle.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr != '0) begin
      if (w_commit && (rs1_addr == rd_wb)) rs1_data = wb_data;
      else                                 rs1_data = regs_q[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != '0) begin
      if (w_commit && (rs2_addr == rd_wb)) rs2_data = wb_data;
      else                                 rs2_data = regs_q[rs2_addr];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
//  Module   : tb_wb_regfile
//  Summary  : Scoreboard bench for wb_regfile against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_out_wb;
  logic [31:0] mem_data_wb;
  logic [4:0]  rd_wb;
  logic        reg_write_wb;
  logic        mem_to_reg_wb;
  logic [1:0]  load_size_wb;
  logic        load_unsigned_wb;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_data;
  logic [31:0] wr_count;

  wb_regfile #(.D_WIDTH(32), .RF_SIZE(5)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alu_out_wb       (alu_out_wb),
    .mem_data_wb      (mem_data_wb),
    .rd_wb            (rd_wb),
    .reg_write_wb     (reg_write_wb),
    .mem_to_reg_wb    (mem_to_reg_wb),
    .load_size_wb     (load_size_wb),
    .load_unsigned_wb (load_unsigned_wb),
    .rs1_addr         (rs1_addr),
    .rs2_addr         (rs2_addr),
    .rs1_data         (rs1_data),
    .rs2_data         (rs2_data),
    .wb_data          (wb_data),
    .wr_count         (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] wb;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  event        item_ev;
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model [32];
  logic [31:0] cnt_m;

  // Reference model: architectural state as a plain array and a counter.
  function automatic logic [31:0] fmt_load(input logic [31:0] mem, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = (mem >> (8 * off)) & 32'hFF;
        if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      2'd1: begin
        v = (mem >> (16 * (off / 2))) & 32'hFFFF;
        if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: v = mem;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic commit,
                                             input logic [4:0] rd, input logic [31:0] wbv);
    if (a == 5'd0) return 32'd0;
    if (commit && a == rd) return wbv;
    return model[a];
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(item_ev);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cmp("rs1_data", rs1_data, e.rs1);
        cmp("rs2_data", rs2_data, e.rs2);
        cmp("wb_data",  wb_data,  e.wb);
        cmp("wr_count", wr_count, e.cnt);
      end
    end
  end

  // Called just after a falling edge; issues one cycle and advances the model.
  task automatic cycle(input logic we, input logic [4:0] rd, input logic m2r,
                       input logic [1:0] sz, input logic uns, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [4:0] a1, input logic [4:0] a2);
    exp_t        e;
    logic [31:0] wbv;
    logic        commit;
    reg_write_wb = we;  rd_wb = rd;  mem_to_reg_wb = m2r;  load_size_wb = sz;
    load_unsigned_wb = uns;  alu_out_wb = alu;  mem_data_wb = mem;
    rs1_addr = a1;  rs2_addr = a2;
    #1;
    wbv    = m2r ? fmt_load(mem, alu[1:0], sz, uns) : alu;
    commit = we && (rd != 5'd0);
    e.rs1  = model_read(a1, commit, rd, wbv);
    e.rs2  = model_read(a2, commit, rd, wbv);
    e.wb   = wbv;
    e.cnt  = cnt_m;
    exp_q.push_back(e);
    -> item_ev;
    @(posedge clk);
    if (rst_n && commit) begin
      model[rd] = wbv;
      cnt_m     = cnt_m + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    cnt_m = 32'd0;
  endtask

  initial begin : stim
    logic [31:0] ld;
    logic [4:0]  rd;
    exp_t        e;
    model_reset();
    rst_n = 1'b0;
    reg_write_wb = 1'b0; rd_wb = '0; mem_to_reg_wb = 1'b0; load_size_wb = '0;
    load_unsigned_wb = 1'b0; alu_out_wb = '0; mem_data_wb = '0;
    rs1_addr = '0; rs2_addr = '0;
    repeat (2) @(negedge clk);
    // A write attempted while reset is held must not land.
    cycle(1'b1, 5'd9, 1'b0, 2'd2, 1'b0, 32'h5555_AAAA, 32'd0, 5'd9, 5'd1);
    rst_n = 1'b1;

    for (int a = 0; a < 32; a++)
      cycle(1'b0, 5'd0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 5'(a), 5'(31 - a));

    cycle(1'b1, 5'd5, 1'b0, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'd0, 5'd5, 5'd5);
    cycle(1'b0, 5'd5, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 5'd5, 5'd5);

    cycle(1'b1, 5'd0, 1'b0, 2'd2, 1'b0, 32'h1234_5678, 32'd0, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 5'd0, 5'd5);

    ld = 32'h80FF_7F01;
    cycle(1'b1, 5'd7, 1'b1, 2'd0, 1'b0, 32'h0000_1003, ld, 5'd7, 5'd0);
    cycle(1'b0, 5'd0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 5'd7, 5'd7);
    cycle(1'b1, 5'd7, 1'b1, 2'd0, 1'b1, 32'h0000_1001, ld, 5'd7, 5'd0);
    cycle(1'b0, 5'd0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 5'd7, 5'd7);
    cycle(1'b1, 5'd7, 1'b1, 2'd1, 1'b0, 32'h0000_1002, ld, 5'd7, 5'd0);
    cycle(1'b0, 5'd0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 5'd7, 5'd7);
    cycle(1'b1, 5'd7, 1'b1, 2'd1, 1'b1, 32'h0000_1000, ld, 5'd7, 5'd0);
    cycle(1'b0, 5'd0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 5'd7, 5'd7);
    cycle(1'b1, 5'd7, 1'b1, 2'd2, 1'b0, 32'h0000_1003, ld, 5'd7, 5'd0);
    cycle(1'b0, 5'd0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 5'd7, 5'd7);
    cycle(1'b1, 5'd7, 1'b1, 2'd3, 1'b1, 32'h0000_1002, ld, 5'd7, 5'd7);

    cycle(1'b1, 5'd3, 1'b0, 2'd2, 1'b0, 32'h1, 32'd0, 5'd3, 5'd3);
    cycle(1'b1, 5'd3, 1'b0, 2'd2, 1'b0, 32'h2, 32'd0, 5'd3, 5'd3);
    cycle(1'b0, 5'd3, 1'b0, 2'd2, 1'b0, 32'h0, 32'd0, 5'd3, 5'd3);

    for (int r = 1; r <= 4; r++)
      cycle(1'b1, 5'(r), 1'b0, 2'd2, 1'b0, 32'hA000_0000 + r, 32'd0, 5'(r), 5'(5 - r));

    // Asynchronous reset between edges while a write is presented.
    reg_write_wb = 1'b1; rd_wb = 5'd2; mem_to_reg_wb = 1'b0; alu_out_wb = 32'h0000_AAAA;
    rs1_addr = 5'd1; rs2_addr = 5'd4;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    e.rs1 = 32'd0; e.rs2 = 32'd0; e.wb = 32'h0000_AAAA; e.cnt = 32'd0;
    exp_q.push_back(e);
    -> item_ev;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 1; r <= 4; r++)
      cycle(1'b0, 5'd0, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 5'(r), 5'd2);

    for (int n = 0; n < 600; n++) begin
      rd = 5'($urandom);
      cycle(1'($urandom), rd, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
            ($urandom_range(0, 3) == 0) ? rd : 5'($urandom),
            ($urandom_range(0, 3) == 0) ? rd : 5'($urandom));
    end

    #2;
    cmp("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the 5-stage core. Consumes the MEM/WB pipeline register outputs, formats load data (byte/half/word, sign/zero extension), selects the writeback value, and commits it to a 2^RF_SIZE-entry register file. Provides two combinational read ports with write-first bypass to the decode stage, plus a committed-write counter for debug and performance.

## Interface
- D_WIDTH, 32, datapath width; load formatting is defined for 32 only.
- RF_SIZE, 5, register address width; 2^RF_SIZE registers, register 0 hardwired to zero.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_out_wb  in  D_WIDTH  ALU result from MEM/WB; bits [1:0] are the load byte offset.
- mem_data_wb  in  D_WIDTH  raw aligned word read from data memory.
- rd_wb  in  RF_SIZE  destination register.
- reg_write_wb  in  1  commit enable.
- mem_to_reg_wb  in  1  1 = write formatted load data, 0 = write alu_out_wb.
- load_size_wb  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- load_unsigned_wb  in  1  1 = zero-extend, 0 = sign-extend (byte/half only).
- rs1_addr  in  RF_SIZE  read port 1 address.
- rs2_addr  in  RF_SIZE  read port 2 address.
- rs1_data  out  D_WIDTH  read port 1 data, combinational.
- rs2_data  out  D_WIDTH  read port 2 data, combinational.
- wb_data  out  D_WIDTH  selected writeback value, combinational (forwarding source for EX).
- wr_count  out  32  number of committed writes, wraps modulo 2^32.

## Operation
- Load formatting (combinational): byte = mem_data_wb[8*off +: 8], off = alu_out_wb[1:0]; half = mem_data_wb[16*off[1] +: 16], off[0] ignored; word = mem_data_wb, offset ignored. Byte/half zero- or sign-extended to D_WIDTH per load_unsigned_wb.
- wb_data = mem_to_reg_wb ? formatted load : alu_out_wb. Valid regardless of reg_write_wb.
- Commit: on rising clk, if reg_write_wb=1 and rd_wb!=0, regs[rd_wb] <= wb_data and wr_count <= wr_count+1. Writes to rd_wb=0 are discarded and do not increment wr_count.
- Read ports: address 0 returns 0. If reg_write_wb=1, rd_wb!=0 and rsN_addr==rd_wb, rsN_data = wb_data (write-first bypass, same cycle). Otherwise rsN_data = regs[rsN_addr].
- Both ports may address the same register, including the one being written; both receive bypassed value.
- Reset (rst_n=0, asynchronous): all registers 0, wr_count 0. rs1_data/rs2_data therefore read 0 except via bypass; wb_data stays combinational from inputs. Reset asserted mid-write: write is lost, registers read 0 after reset.

## Timing
- Read latency 0 cycles (combinational from addresses and WB inputs).
- Write latency 1 edge: value visible from storage on the cycle after commit; visible via bypass in the commit cycle itself.
- wr_count updates on the same edge as the register write.
- No stalls or handshakes; one commit per cycle max.
- Reset release synchronous to next rising clk; first commit may occur on the first edge after rst_n rises.

## Test plan
- Reset: hold rst_n=0, then release; read all 32 addresses on both ports -> 0; wr_count=0.
- ALU write + bypass: reg_write_wb=1, mem_to_reg_wb=0, rd_wb=5, alu_out_wb=0xDEADBEEF, rs1_addr=rs2_addr=5 -> both ports 0xDEADBEEF in same cycle; next cycle with reg_write_wb=0 -> still 0xDEADBEEF; wr_count=1.
- x0 protection: write rd_wb=0, alu_out_wb=0x12345678 -> rs1_addr=0 reads 0 in both cycles; wr_count unchanged.
- Load formatting: mem_data_wb=0x80FF7F01; byte signed off 3 -> 0xFFFFFF80; byte unsigned off 1 -> 0x0000007F; half signed off 2 -> 0xFFFF80FF; half unsigned off 0 -> 0x00007F01; word -> 0x80FF7F01; check wb_data and committed value for rd_wb=7.
- Back-to-back writes same register: cycle 1 rd=3 val 0x1, cycle 2 rd=3 val 0x2 -> cycle 2 read shows 0x2 (bypass), cycle 3 read shows 0x2; wr_count +2.
- Async reset mid-operation: after writing regs 1..4, pulse rst_n low between clock edges -> outputs read 0 immediately, wr_count=0 without waiting for clk.
